bitwise_nand_bist: RTL
======================

Name: bitwise_nand_bist

Overview:
- Synthesizable exhaustive self-test engine for the combinational/pipelined bitwise NAND datapath.
- Acts as the driving and checking side of the operand/result interface:
  - sweeps every (var1, var2) operand pair into an external NAND unit;
  - samples the returned result after a fixed latency and compares it to an internally computed golden value;
  - counts mismatches and reports pass/fail.
- Sits beside the NAND unit under a test-mode mux; software or a top-level controller pulses start and reads status.

Parameters:
- WIDTH, 4, operand/result width in bits; sweep length is 2**(2*WIDTH) vectors.
- LATENCY, 0, register stages in the unit under test (0 = purely combinational); results are sampled LATENCY cycles after the operands are driven.
- ERR_W, 16, width of the saturating error counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse; sampled only in IDLE or DONE.
- o_var1  out  WIDTH  operand A driven to the unit.
- o_var2  out  WIDTH  operand B driven to the unit.
- i_res  in  WIDTH  result returned by the unit.
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  high in DONE.
- o_pass  out  1  high in DONE when error count is 0.
- o_err_count  out  ERR_W  mismatches seen in the current sweep, saturating.
- o_first_err_valid  out  1  a mismatch has been captured in this sweep.
- o_first_err_var1  out  WIDTH  var1 of the first failing vector.
- o_first_err_var2  out  WIDTH  var2 of the first failing vector.
- o_first_err_res  out  WIDTH  i_res observed for the first failing vector.

Behaviour:
- Clocking and reset:
  - Single clock, rising-edge registers throughout.
  - i_rst_n low asynchronously forces state to IDLE.
  - On reset, every output and internal register goes to 0: vector counter, golden/valid pipeline, error count, first-error capture, o_var1/o_var2, o_busy/o_done/o_pass.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --i_start--> RUN.
  - RUN --last vector issued--> DRAIN if LATENCY>0, else DONE.
  - DRAIN --LATENCY cycles elapsed--> DONE.
  - DONE --i_start--> RUN.
  - DONE otherwise holds indefinitely.
  - i_start in RUN/DRAIN is ignored.
- Start:
  - The edge that samples i_start (edge 0) enters RUN.
  - The same edge clears error count, first-error fields and vector counter, and drives vector 0 (var1=0, var2=0).
- Vector order:
  - 2*WIDTH-bit counter with var1 = upper WIDTH bits and var2 = lower bits, i.e. var2 inner loop.
  - Vector n is driven after edge n, for n = 0..2**(2W)-1; one new vector per clock, no stalls.
- Golden/check pipeline:
  - Alongside each driven vector, push {valid=1, golden=~(var1&var2), var1, var2} into a LATENCY-deep shift register; with LATENCY=0 the pipeline is pass-through.
  - At edge n+LATENCY+1, the entry for vector n is compared against i_res; a mismatch on any bit counts as one error.
- Error counter and first-error capture:
  - The counter saturates at 2**ERR_W-1 and never wraps.
  - The first mismatch latches var1/var2/i_res and sets o_first_err_valid; later mismatches do not overwrite it.
- Completion:
  - o_var1/o_var2 return to 0 after the edge that leaves RUN.
  - The valid bit of the final vector exits the pipeline at edge 2**(2W)+LATENCY, which enters DONE.
  - o_done/o_pass are registered, visible after that edge.
- Busy/done flags:
  - o_busy is high from edge 0 until that DONE edge.
  - o_done and o_busy are never high together.
- Status retention: error count and first-error fields hold in DONE until the next start or reset.
- Reset mid-sweep: all state is discarded per the reset clause; the next i_start begins a fresh full sweep.

Test Plan:
- WIDTH=4, LATENCY=0, correct NAND model; pulse i_start -> 256 distinct vectors in var2-inner order; o_done rises 256 edges after the start edge; o_err_count=0, o_pass=1, o_first_err_valid=0.
- Same setup but result bit0 stuck at 0 -> o_err_count=192; first error captured as var1=0, var2=0, res=0xE; o_pass=0.
- LATENCY=2 with a 2-register NAND model -> o_pass=1, o_done 258 edges after start; repeat with LATENCY=1 against the same 2-stage model -> nonzero errors.
- ERR_W=4, bit0 stuck fault -> o_err_count saturates at 15, no wrap.
- Assert i_rst_n low asynchronously at vector 100 -> all outputs 0 immediately, state IDLE; a new i_start completes a clean 256-vector sweep with o_pass=1.
- Pulse i_start again at vector 50 -> ignored, sweep unchanged; i_start in DONE after a failing run -> counters cleared on the start edge, and a good DUT then yields o_pass=1.

Source files
------------

// File: rtl/bitwise_nand_bist.sv
// Exhaustive self-test engine for a bitwise NAND unit: sweeps every operand pair,
// checks the returned result against a golden pipeline and reports pass/fail.
`timescale 1ns/1ps

module bitwise_nand_bist #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 0,
    parameter int ERR_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_var1,
    output logic [WIDTH-1:0] o_var2,
    input  logic [WIDTH-1:0] i_res,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_first_err_valid,
    output logic [WIDTH-1:0] o_first_err_var1,
    output logic [WIDTH-1:0] o_first_err_var2,
    output logic [WIDTH-1:0] o_first_err_res
);

    // state | meaning
    // IDLE  | waiting for the first start after reset
    // RUN   | driving one operand pair per clock
    // DRAIN | sweep issued, waiting for the last results to come back
    // DONE  | status valid and held until the next start

    localparam int VW = 2 * WIDTH;
    localparam int EW = 1 + 3 * WIDTH;
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   vec_cnt;
    logic            drv_valid;
    logic [DW-1:0]   drain_cnt;
    logic [EW-1:0]   drv_entry;
    logic [EW-1:0]   chk_entry;
    logic            start_ok;
    logic            last_vec;
    logic            chk_valid;
    logic [WIDTH-1:0] chk_golden;
    logic [WIDTH-1:0] chk_var1;
    logic [WIDTH-1:0] chk_var2;
    logic            mismatch;
    logic [ERR_W-1:0] err_nxt;

    assign start_ok = i_start && ((state == S_IDLE) || (state == S_DONE));
    assign last_vec = (vec_cnt == '1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (last_vec) state_nxt = (LATENCY > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
            S_DONE:  if (i_start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Each entry travels with its operands so a failure can be reported by vector.
    assign drv_entry = {drv_valid, ~(o_var1 & o_var2), o_var1, o_var2};

    generate
        if (LATENCY == 0) begin : g_comb
            assign chk_entry = drv_entry;
        end else begin : g_pipe
            logic [EW-1:0] pipe [LATENCY];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= drv_entry;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign chk_entry = pipe[LATENCY-1];
        end
    endgenerate

    assign chk_valid  = chk_entry[EW-1];
    assign chk_golden = chk_entry[EW-2 -: WIDTH];
    assign chk_var1   = chk_entry[2*WIDTH-1 -: WIDTH];
    assign chk_var2   = chk_entry[WIDTH-1:0];
    assign mismatch   = chk_valid && (i_res != chk_golden);
    assign err_nxt    = (mismatch && !(&o_err_count)) ? o_err_count + 1'b1 : o_err_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= S_IDLE;
            vec_cnt           <= '0;
            drv_valid         <= 1'b0;
            drain_cnt         <= '0;
            o_var1            <= '0;
            o_var2            <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_pass            <= 1'b0;
            o_err_count       <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_var1  <= '0;
            o_first_err_var2  <= '0;
            o_first_err_res   <= '0;
        end else begin
            state  <= state_nxt;
            o_busy <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            o_done <= (state_nxt == S_DONE);
            if (start_ok) begin
                vec_cnt           <= '0;
                drv_valid         <= 1'b1;
                o_var1            <= '0;
                o_var2            <= '0;
                o_pass            <= 1'b0;
                o_err_count       <= '0;
                o_first_err_valid <= 1'b0;
                o_first_err_var1  <= '0;
                o_first_err_var2  <= '0;
                o_first_err_res   <= '0;
            end else begin
                if (state == S_RUN) begin
                    if (last_vec) begin
                        drv_valid <= 1'b0;
                        o_var1    <= '0;
                        o_var2    <= '0;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        vec_cnt          <= vec_cnt + 1'b1;
                        {o_var1, o_var2} <= vec_cnt + 1'b1;
                    end
                end
                if ((state == S_DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - 1'b1;
                o_err_count <= err_nxt;
                if (mismatch && !o_first_err_valid) begin
                    o_first_err_valid <= 1'b1;
                    o_first_err_var1  <= chk_var1;
                    o_first_err_var2  <= chk_var2;
                    o_first_err_res   <= i_res;
                end
                // The final compare lands on the DONE edge, so pass must see it.
                if ((state_nxt == S_DONE) && (state != S_DONE)) o_pass <= (err_nxt == '0);
            end
        end
    end

endmodule
